// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end for the 5-stage MIPS core.
//
// Generates sequential fetch PCs and issues them to a variable-latency
// instruction memory. In-order responses are buffered in a small prefetch
// FIFO and presented to decode as {pc, instr}. Branch redirects flush the
// FIFO and mark every in-flight response as stale.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     word-aligned fetch address
//   imem_resp_valid   response valid (responses return in request order)
//   imem_resp_data    instruction word
//   id_valid          FIFO head valid toward IF/ID
//   id_pc, id_instr   head PC / instruction (zero when empty)
//   id_ready          decode consumes the head (~stall)
//   redirect_valid    branch/jump redirect, flushes the wrong path
//   redirect_pc       new fetch address (bits [1:0] forced to 0)
//   busy              requests still in flight, or draining stale ones
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [0:0] {FETCH = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, resp_pc;
  logic [CW-1:0] count, count_next;
  logic [OW-1:0] outstanding, out_next;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic        accept, resp_ok, push, pop, credit_ok;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // Credit: an entry is reserved in the FIFO for every in-flight request,
  // so a returning response always finds a free slot.
  assign credit_ok = ({1'b0, count} + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);

  assign accept  = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding (e.g. one that straddled a reset)
  // is not ours and is ignored entirely.
  assign resp_ok = imem_resp_valid && (outstanding != '0);
  // Responses are live only in FETCH and not in a redirect cycle; the
  // count guard protects the FIFO against a misbehaving memory.
  assign push    = resp_ok && (state == FETCH) && !redirect_valid &&
                   (count != CW'(DEPTH));
  assign pop     = id_valid && id_ready && !redirect_valid;

  assign out_next   = outstanding + OW'(accept) - OW'(resp_ok);
  assign count_next = count + CW'(push) - CW'(pop);

  assign imem_req_addr = fetch_pc;
  assign id_valid      = (count != '0);
  assign id_pc         = id_valid ? pc_mem[rd_ptr]    : 32'h0;
  assign id_instr      = id_valid ? instr_mem[rd_ptr] : 32'h0;
  assign busy          = (outstanding != '0) || (state == DRAIN);

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    if (!rst && state == FETCH && !redirect_valid &&
        outstanding < OW'(MAX_OUT) && credit_ok)
      imem_req_valid = 1'b1;
    case (state)
      // Any request still in flight after a redirect returns wrong-path data.
      FETCH:   if (redirect_valid && out_next != '0) state_next = DRAIN;
      DRAIN:   if (!redirect_valid && out_next == '0) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_next;
      outstanding <= out_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        resp_pc  <= redirect_tgt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count_next;
      end
    end
  end

  // Payload storage needs no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_resp_data;
    end
  end

  // Protocol check: a response needs an outstanding request and a free slot.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(imem_resp_valid && (outstanding == '0 || count == CW'(DEPTH))));
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end feeding the IF/ID pipeline register of the 5-stage MIPS core.
- Generates sequential fetch PCs and issues them to a variable-latency instruction memory or I-cache over a valid/ready request channel.
- Buffers in-order responses in a small prefetch FIFO and presents {pc, instr} to decode.
- Honours decode back-pressure (hazard stall) and branch redirects, discarding wrong-path responses.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
MAX_OUT, 2, maximum in-flight imem requests (1..DEPTH)
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_resp_valid  in  1  response data valid; responses return strictly in request order
imem_resp_data  in  32  instruction word
id_valid  out  1  FIFO head valid toward IF/ID
id_pc  out  32  PC of head instruction
id_instr  out  32  head instruction; 32'h00000000 (nop) when empty
id_ready  in  1  decode consumes head (driven by ~stall)
redirect_valid  in  1  branch/jump redirect; flush wrong path
redirect_pc  in  32  new fetch address (bits[1:0] ignored, forced 0)
busy  out  1  outstanding != 0 or state == DRAIN

Behaviour:
- Reset: fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO count=0, outstanding=0, state=FETCH. Outputs: imem_req_valid=0, id_valid=0, id_pc=0, id_instr=0, busy=0. Reset mid-operation discards all FIFO contents and in-flight state; responses arriving after reset release with outstanding==0 are ignored.
- State machine, two states:
  - FETCH: normal operation.
  - DRAIN: every in-flight response is stale.
  - FETCH->DRAIN on redirect when outstanding minus same-cycle resp is >0.
  - DRAIN->FETCH in the cycle after outstanding reaches 0.
  - A redirect while in DRAIN updates the PCs and stays in DRAIN.
- Request issue (combinational):
  - imem_req_valid = state==FETCH && !redirect_valid && outstanding<MAX_OUT && count+outstanding<DEPTH.
  - imem_req_addr = fetch_pc.
  - Accept = valid&&ready; on accept, fetch_pc += 4 (mod 2^32 wrap) and outstanding++.
- Credit rule: count+outstanding never exceeds DEPTH, so a response always has a free slot. Response with FIFO full or outstanding==0 is a protocol error: ignore the response, flag a simulation assertion.
- Response (FETCH):
  - Push {resp_pc, imem_resp_data}, resp_pc += 4, outstanding--.
  - Accept and response in the same cycle leave outstanding unchanged.
- Response (DRAIN): dropped, outstanding--.
- Output side:
  - id_valid = count!=0. id_pc/id_instr are taken from the FIFO head.
  - Pop when id_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Minimum latency is response in cycle T -> id_valid in T+1. There is no same-cycle bypass.
  - While id_ready=0, head outputs hold stable.
- Redirect (highest priority):
  - Same cycle: FIFO flushed (count=0, pointers reset), fetch_pc=resp_pc={redirect_pc[31:2],2'b00}, no request issued, no pop performed.
  - A same-cycle response is treated as stale.
  - id_valid=0 next cycle.
- Back-to-back redirects: the last one wins. Each redirect re-flushes.
- Throughput: with imem_req_ready=1, single-cycle responses, and id_ready=1, sustains one instruction per cycle after 2-cycle startup.

Test Plan:
- Reset release, imem 1-cycle latency, ready=1, id_ready=1:
  - First imem_req_addr=0x0 in cycle 1.
  - id_valid from cycle 3.
  - id_pc sequence 0x0,0x4,0x8,... one per cycle; id_instr matches memory image.
- id_ready=0 for 10 cycles:
  - Requests stop once count+outstanding==4; exactly DEPTH=4 entries held; head pc stable.
  - On release, pcs continue with no gap or duplicate.
- Redirect to 0x40 while 2 requests are outstanding with 3-cycle memory latency:
  - Both stale responses dropped; busy=1 during DRAIN.
  - First request after drain addr=0x40; first id_pc=0x40.
- Redirect coincident with imem_resp_valid and id_valid&&id_ready:
  - FIFO empty next cycle; response discarded.
  - Next issued addr=redirect_pc.
- redirect_pc=0xFFFFFFFC:
  - Fetches 0xFFFFFFFC then wraps to 0x00000000; id_pc follows.
- Assert rst while the FIFO is half full and 1 request is outstanding:
  - All outputs go to 0 immediately; a late response is ignored.
  - Fetch restarts at RESET_PC.
